// File: rtl/reg_init_rsp_if.sv
// Register-init handshake bundle between the init controller (master) and the
// responder (slave): start/end handshake, done flag, config values, shadows and status.
interface reg_init_rsp_if;
    logic        init_hs_start;
    logic        init_hs_end;
    logic        init_done_in;
    logic [31:0] reg0_in;
    logic [31:0] reg1_in;
    logic [31:0] reg2_in;
    logic        err_clr;
    logic [31:0] shadow0;
    logic [31:0] shadow1;
    logic [31:0] shadow2;
    logic        cfg_valid;
    logic        init_ack;
    logic        init_err;
    logic [1:0]  err_code;

    modport master (
        output init_hs_start, init_hs_end, init_done_in,
        output reg0_in, reg1_in, reg2_in, err_clr,
        input  shadow0, shadow1, shadow2, cfg_valid, init_ack, init_err, err_code
    );

    modport slave (
        input  init_hs_start, init_hs_end, init_done_in,
        input  reg0_in, reg1_in, reg2_in, err_clr,
        output shadow0, shadow1, shadow2, cfg_valid, init_ack, init_err, err_code
    );
endinterface

// File: rtl/reg_init_rsp.sv
// Responder end of the register-init handshake: shadows three config registers and
// raises cfg_valid after a clean sequence. Define REG_INIT_CHECK_EN to compare against EXPn.
module reg_init_rsp #(
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [31:0] EXP0        = 32'hDEADBEEF,
    parameter logic [31:0] EXP1        = 32'hFEEDFACE,
    parameter logic [31:0] EXP2        = 32'hC001D00D
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_init_rsp_if.slave     bus
);

    localparam int TW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC == 0) ? '0 : TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMR_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_END = 3'd1,
        CAPTURE  = 3'd2,
        CHECK    = 3'd3,
        READY    = 3'd4,
        ERROR    = 3'd5
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [1:0]    err_code, err_code_d;
    logic          start_q, end_q;
    logic          start_rise, end_rise;
    logic          capture, ack_d, ack_q, mismatch;
    logic [31:0]   shadow0_q, shadow1_q, shadow2_q;

    assign start_rise = bus.init_hs_start & ~start_q;
    assign end_rise   = bus.init_hs_end & ~end_q;

`ifdef REG_INIT_CHECK_EN
    assign mismatch = (bus.reg0_in != EXP0) | (bus.reg1_in != EXP1) | (bus.reg2_in != EXP2);
`else
    assign mismatch = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            err_code  <= 2'b00;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            ack_q     <= 1'b0;
            shadow0_q <= '0;
            shadow1_q <= '0;
            shadow2_q <= '0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            err_code <= err_code_d;
            start_q  <= bus.init_hs_start;
            end_q    <= bus.init_hs_end;
            ack_q    <= ack_d;
            if (capture) begin
                shadow0_q <= bus.reg0_in;
                shadow1_q <= bus.reg1_in;
                shadow2_q <= bus.reg2_in;
            end
        end
    end

    // In WAIT_END an end edge beats both a restart and the timeout on the same cycle.
    always_comb begin
        state_d    = state;
        timer_d    = timer;
        err_code_d = err_code;
        capture    = 1'b0;
        ack_d      = 1'b0;
        case (state)
            IDLE: begin
                if (end_rise) begin
                    state_d    = ERROR;
                    err_code_d = 2'b01;
                end else if (start_rise) begin
                    state_d = WAIT_END;
                    timer_d = '0;
                end
            end
            WAIT_END: begin
                if (end_rise) begin
                    state_d = CAPTURE;
                end else if (start_rise) begin
                    timer_d = '0;
                end else if ((TIMEOUT_CYC != 0) && (timer == TMO_LAST)) begin
                    state_d    = ERROR;
                    err_code_d = 2'b10;
                end else if (timer != TMR_MAX) begin
                    timer_d = timer + TW'(1);
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                if (!bus.init_done_in) begin
                    state_d    = ERROR;
                    err_code_d = 2'b01;
                end else if (mismatch) begin
                    state_d    = ERROR;
                    err_code_d = 2'b11;
                end else begin
                    state_d = READY;
                    ack_d   = 1'b1;
                end
            end
            READY: begin
                if (start_rise) begin
                    state_d = WAIT_END;
                    timer_d = '0;
                end
            end
            ERROR: begin
                if (bus.err_clr) begin
                    err_code_d = 2'b00;
                    timer_d    = '0;
                    state_d    = start_rise ? WAIT_END : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.shadow0   = shadow0_q;
    assign bus.shadow1   = shadow1_q;
    assign bus.shadow2   = shadow2_q;
    assign bus.cfg_valid = (state == READY);
    assign bus.init_ack  = ack_q;
    assign bus.init_err  = (state == ERROR);
    assign bus.err_code  = err_code;

endmodule

// File: tb/tb_reg_init_rsp.sv
// Directed bench for reg_init_rsp: normal init, re-init, timeout, protocol errors,
// missing done, async reset mid-sequence and level-held start at reset release.
module tb_reg_init_rsp;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    reg_init_rsp_if bus ();

    reg_init_rsp #(.TIMEOUT_CYC(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_regs(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
        bus.reg0_in = r0;
        bus.reg1_in = r1;
        bus.reg2_in = r2;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n             = 1'b0;
        bus.init_hs_start = 1'b0;
        bus.init_hs_end   = 1'b0;
        bus.init_done_in  = 1'b0;
        bus.err_clr       = 1'b0;
        set_regs(32'h0, 32'h0, 32'h0);

        repeat (3) tick();
        check_output("rst_cfg_valid", 32'(bus.cfg_valid), 32'd0);
        check_output("rst_init_err",  32'(bus.init_err),  32'd0);
        check_output("rst_err_code",  32'(bus.err_code),  32'd0);
        check_output("rst_shadow0",   bus.shadow0,        32'd0);
        rst_n = 1'b1;
        tick();

        // Normal init sequence
        bus.init_hs_start = 1'b1;
        tick();
        bus.init_hs_start = 1'b0;
        tick();
        bus.init_hs_end  = 1'b1;
        bus.init_done_in = 1'b1;
        set_regs(32'hDEADBEEF, 32'hFEEDFACE, 32'hC001D00D);
        tick();
        check_output("t1_cfg_valid_capture", 32'(bus.cfg_valid), 32'd0);
        bus.init_hs_end = 1'b0;
        tick();
        check_output("t1_shadow0", bus.shadow0, 32'hDEADBEEF);
        check_output("t1_shadow1", bus.shadow1, 32'hFEEDFACE);
        check_output("t1_shadow2", bus.shadow2, 32'hC001D00D);
        check_output("t1_cfg_valid_check", 32'(bus.cfg_valid), 32'd0);
        tick();
        check_output("t1_cfg_valid", 32'(bus.cfg_valid), 32'd1);
        check_output("t1_init_ack",  32'(bus.init_ack),  32'd1);
        check_output("t1_init_err",  32'(bus.init_err),  32'd0);
        tick();
        check_output("t1_ack_pulse", 32'(bus.init_ack), 32'd0);

        // Level-held end in READY is ignored
        bus.init_hs_end = 1'b1;
        tick();
        tick();
        check_output("ready_end_ignored", 32'(bus.cfg_valid), 32'd1);
        bus.init_hs_end = 1'b0;
        tick();

        // Re-init from READY with new values
        bus.init_hs_start = 1'b1;
        tick();
        check_output("t5_cfg_valid_drop", 32'(bus.cfg_valid), 32'd0);
        bus.init_hs_start = 1'b0;
        set_regs(32'd1, 32'd2, 32'd3);
        bus.init_hs_end = 1'b1;
        tick();
        bus.init_hs_end = 1'b0;
        tick();
        check_output("t5_shadow0", bus.shadow0, 32'd1);
        check_output("t5_shadow1", bus.shadow1, 32'd2);
        check_output("t5_shadow2", bus.shadow2, 32'd3);
        tick();
        check_output("t5_cfg_valid", 32'(bus.cfg_valid), 32'd1);
        check_output("t5_init_ack",  32'(bus.init_ack),  32'd1);

        // Timeout: start with no end for 64 cycles
        bus.init_hs_start = 1'b1;
        tick();
        bus.init_hs_start = 1'b0;
        repeat (63) tick();
        check_output("t2_no_err_63", 32'(bus.init_err), 32'd0);
        tick();
        check_output("t2_init_err",  32'(bus.init_err),  32'd1);
        check_output("t2_err_code",  32'(bus.err_code),  32'd2);
        check_output("t2_cfg_valid", 32'(bus.cfg_valid), 32'd0);
        check_output("t2_shadow_hold", bus.shadow1, 32'd2);
        tick();
        tick();
        check_output("t2_err_code_sticky", 32'(bus.err_code), 32'd2);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_output("t2_clr_init_err", 32'(bus.init_err), 32'd0);
        check_output("t2_clr_err_code", 32'(bus.err_code), 32'd0);

        // End rise while IDLE
        bus.init_hs_end = 1'b1;
        tick();
        bus.init_hs_end = 1'b0;
        check_output("t3a_init_err", 32'(bus.init_err), 32'd1);
        check_output("t3a_err_code", 32'(bus.err_code), 32'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_output("t3a_clr_err_code", 32'(bus.err_code), 32'd0);

        // Start and end rising together
        bus.init_hs_start = 1'b1;
        bus.init_hs_end   = 1'b1;
        tick();
        bus.init_hs_start = 1'b0;
        bus.init_hs_end   = 1'b0;
        check_output("t3b_err_code",  32'(bus.err_code),  32'd1);
        check_output("t3b_cfg_valid", 32'(bus.cfg_valid), 32'd0);
        tick();

        // err_clr with a start edge goes straight to WAIT_END; then end with done low
        bus.err_clr       = 1'b1;
        bus.init_hs_start = 1'b1;
        tick();
        bus.err_clr       = 1'b0;
        bus.init_hs_start = 1'b0;
        check_output("clr_start_init_err", 32'(bus.init_err), 32'd0);
        bus.init_done_in = 1'b0;
        bus.init_hs_end  = 1'b1;
        tick();
        bus.init_hs_end = 1'b0;
        tick();
        tick();
        check_output("t4_done_low_err",  32'(bus.init_err), 32'd1);
        check_output("t4_done_low_code", 32'(bus.err_code), 32'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;

        // reg1 zero: mismatch only when the compare is built in
        bus.init_done_in = 1'b1;
        set_regs(32'hDEADBEEF, 32'h0, 32'hC001D00D);
        bus.init_hs_start = 1'b1;
        tick();
        bus.init_hs_start = 1'b0;
        tick();
        bus.init_hs_end = 1'b1;
        tick();
        bus.init_hs_end = 1'b0;
        tick();
        tick();
`ifdef REG_INIT_CHECK_EN
        check_output("t4_mismatch_code", 32'(bus.err_code),  32'd3);
        check_output("t4_mismatch_err",  32'(bus.init_err),  32'd1);
`else
        check_output("t4_nocheck_valid", 32'(bus.cfg_valid), 32'd1);
        check_output("t4_nocheck_sh1",   bus.shadow1,        32'd0);
`endif
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;

        // Async reset while in WAIT_END, start held high through release
        set_regs(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678);
        bus.init_hs_start = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t6_rst_shadow0",  bus.shadow0,        32'd0);
        check_output("t6_rst_shadow2",  bus.shadow2,        32'd0);
        check_output("t6_rst_cfg_valid", 32'(bus.cfg_valid), 32'd0);
        check_output("t6_rst_init_err", 32'(bus.init_err),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.init_hs_end = 1'b1;
        tick();
        bus.init_hs_end = 1'b0;
        tick();
        check_output("t6_held_start_sh0", bus.shadow0, 32'hA5A5A5A5);
        tick();
        check_output("t6_held_start_valid", 32'(bus.cfg_valid), 32'd1);
        bus.init_hs_start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
